instr_encoder: RTL and testbench

Field-to-word RV32I instruction encoder covering the nine instruction classes the core decodes: R, LW, ADDI, JALR, S, SB, AUIPC, LUI and UJ. It accepts an instruction type plus register, funct and immediate fields over a valid/ready handshake, and packs them into a 32-bit instruction word. It registers the word together with a byte address that advances by 4 per emitted word, ready for writing into instruction memory by the boot/test-program loader. Illegal requests are dropped and flagged.

---
 rtl/instr_encoder.sv | 114 +++++++++++
 tb/tb_instr_encoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder with a single registered output stage and a byte-address counter.
// Optional macro IMM_CHECK_EN: drop and flag immediates that do not fit their instruction format.
module instr_encoder #(
   parameter int                    ADDR_WIDTH = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  restart,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_type,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [2:0]            in_funct3,
   input  logic [6:0]            in_funct7,
   input  logic [31:0]           in_imm,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_instr,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  err_illegal,
   output logic                  err_imm
);

   localparam logic [3:0] T_R = 4'd0, T_LW = 4'd1, T_ADDI = 4'd2, T_JALR = 4'd3, T_S = 4'd4,
                          T_SB = 4'd5, T_AUIPC = 4'd6, T_LUI = 4'd7, T_UJ = 4'd8;

   logic [31:0] enc;
   logic        legal;
   logic        imm_ok;
   logic        accept;
   logic        out_hs;

   assign in_ready = !restart && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;

`ifdef IMM_CHECK_EN
   logic i12_ok, b13_ok, j21_ok, u_ok;
   assign i12_ok = (in_imm[31:11] == {21{in_imm[11]}});
   assign b13_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
   assign j21_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
   assign u_ok   = (in_imm[11:0] == 12'd0);
`endif

   always_comb begin
      enc    = '0;
      legal  = 1'b1;
      imm_ok = 1'b1;
      case (in_type)
         T_R:     enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'h33};
         T_LW:    enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h03};
         T_ADDI:  enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h13};
         T_JALR:  enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'h67};
         T_S:     enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'h23};
         T_SB:    enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], 7'h63};
         T_AUIPC: enc = {in_imm[31:12], in_rd, 7'h17};
         T_LUI:   enc = {in_imm[31:12], in_rd, 7'h37};
         T_UJ:    enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'h6F};
         default: legal = 1'b0;
      endcase
`ifdef IMM_CHECK_EN
      case (in_type)
         T_LW, T_ADDI, T_JALR, T_S: imm_ok = i12_ok;
         T_SB:                      imm_ok = b13_ok;
         T_AUIPC, T_LUI:            imm_ok = u_ok;
         T_UJ:                      imm_ok = j21_ok;
         default:                   imm_ok = 1'b1;
      endcase
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_instr   <= '0;
         out_addr    <= BASE_ADDR;
         err_illegal <= 1'b0;
      end else if (restart) begin
         out_valid   <= 1'b0;
         out_addr    <= BASE_ADDR;
         err_illegal <= 1'b0;
      end else begin
         // address tracks the held word: it moves on as soon as the current word leaves
         if (out_hs)
            out_addr <= out_addr + ADDR_WIDTH'(4);
         if (accept && legal && imm_ok) begin
            out_valid <= 1'b1;
            out_instr <= enc;
         end else if (out_hs) begin
            out_valid <= 1'b0;
         end
         if (accept && !legal)
            err_illegal <= 1'b1;
      end
   end

`ifdef IMM_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_imm <= 1'b0;
      else if (restart)
         err_imm <= 1'b0;
      else if (accept && legal && !imm_ok)
         err_imm <= 1'b1;
   end
`else
   assign err_imm = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver queues expected words, a monitor checks each output handshake.
module tb_instr_encoder;
   localparam int AW = 4;

   logic          clk = 0;
   logic          rst;
   logic          restart;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_type;
   logic [4:0]    in_rd, in_rs1, in_rs2;
   logic [2:0]    in_funct3;
   logic [6:0]    in_funct7;
   logic [31:0]   in_imm;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_addr;
   logic          err_illegal;
   logic          err_imm;

   instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR('0)) dut (
      .clk(clk), .rst(rst), .restart(restart),
      .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .err_illegal(err_illegal), .err_imm(err_imm)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [AW-1:0] exp_addr = '0;
   logic [31:0]   q_instr[$];
   logic [AW-1:0] q_addr[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // monitor: sampled on the falling edge, a word with out_ready high will handshake next rising edge
   always @(negedge clk) begin
      if (!rst && !restart && out_valid && out_ready) begin
         if (q_instr.size() == 0) begin
            check("unexpected_word", out_instr, 32'hDEADDEAD);
         end else begin
            logic [31:0]   ei;
            logic [AW-1:0] ea;
            ei = q_instr.pop_front();
            ea = q_addr.pop_front();
            check("sb_instr", out_instr, ei);
            check("sb_addr", 32'(out_addr), 32'(ea));
         end
      end
   end

   task automatic send(input logic [3:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input bit emit, input logic [31:0] exp_word);
      int n = 0;
      in_valid = 1; in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm;
      if (emit) begin
         q_instr.push_back(exp_word);
         q_addr.push_back(exp_addr);
         exp_addr = exp_addr + AW'(4);
      end
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (q_instr.size() != 0 && n < 100) begin
         @(posedge clk); n++;
      end
      check("drain", 32'(q_instr.size()), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1; restart = 0; in_valid = 0; out_ready = 1;
      in_type = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_funct3 = 0; in_funct7 = 0; in_imm = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_instr", out_instr, 0);
      check("rst_out_addr", 32'(out_addr), 0);
      check("rst_err_illegal", 32'(err_illegal), 0);
      check("rst_err_imm", 32'(err_imm), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;

      send(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093);
      @(negedge clk);
      check("addi_latency_valid", 32'(out_valid), 1);
      @(posedge clk); #1;
      // back-to-back with no bubble
      send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 32'h002081B3);
      send(4'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1, 32'hFE208EE3);
      @(negedge clk);
      check("sb_follows_r", out_instr, 32'hFE208EE3);
      check("sb_follows_r_valid", 32'(out_valid), 1);
      @(posedge clk); #1;
      send(4'd8, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1, 32'h008000EF);
      send(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093);
      drain();

      // backpressure hold
      out_ready = 0;
      send(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1, 32'h123452B7);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_instr", out_instr, 32'h123452B7);
         check("hold_addr", 32'(out_addr), 32'h4);
         check("hold_in_ready", 32'(in_ready), 0);
      end
      @(posedge clk); #1;
      out_ready = 1;
      send(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093);
      drain();

      // illegal type
      send(4'd15, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 0, 32'h0);
      @(negedge clk);
      check("ill_out_valid", 32'(out_valid), 0);
      check("ill_err", 32'(err_illegal), 1);
      check("ill_addr", 32'(out_addr), 32'hC);
      @(posedge clk); #1;
      restart = 1;
      @(negedge clk);
      check("restart_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      restart = 0;
      exp_addr = '0;
      @(negedge clk);
      check("restart_err", 32'(err_illegal), 0);
      check("restart_addr", 32'(out_addr), 0);
      @(posedge clk); #1;

`ifdef IMM_CHECK_EN
      send(4'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 32'h0);
      @(negedge clk);
      check("imm_err", 32'(err_imm), 1);
      check("imm_drop", 32'(out_valid), 0);
      @(posedge clk); #1;
`else
      send(4'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 32'h80000013);
`endif
      send(4'd3, 5'd1, 5'd2, 5'd0, 3'd7, 7'd0, 32'd0, 1, 32'h000100E7);
      send(4'd4, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1, 32'h0020A423);
      send(4'd1, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, -32'sd4, 1, 32'hFFC0A283);
      send(4'd6, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 1, 32'hABCDE197);
      drain();
      check("final_err_illegal", 32'(err_illegal), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      total_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
